// File: rtl/mult_seq_if.sv
// mult_seq_if: start/busy/done handshake and operand/result bus
// for the sequential MULT/MULTU unit.
interface mult_seq_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 is_signed;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: shift-add multiplier, signed/unsigned, 2*WIDTH-bit product
// over WIDTH+1 clocks with start/busy/done handshake.
module mult_seq #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        reset,
   mult_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [CW-1:0]     count_q;
   logic [PW-1:0]     acc_q;
   logic [PW-1:0]     mcand_q;
   logic [PW-1:0]     result_q;
   logic [WIDTH-1:0]  mplier_q;
   logic              neg_q;
   logic              done_q;

   logic [WIDTH-1:0]  mag_a;
   logic [WIDTH-1:0]  mag_b;
   logic              neg_d;

   // -2^(W-1) negates to itself, which read unsigned is the right magnitude
   always_comb begin
      mag_a = bus.a;
      mag_b = bus.b;
      if (bus.is_signed && bus.a[WIDTH-1])
         mag_a = -bus.a;
      if (bus.is_signed && bus.b[WIDTH-1])
         mag_b = -bus.b;
      neg_d = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start) state_d = CALC;
         CALC: if (count_q == CW'(WIDTH - 1)) state_d = FIX;
         FIX:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                  mplier_q <= mag_b;
                  neg_q    <= neg_d;
                  acc_q    <= '0;
                  count_q  <= '0;
               end
            end
            CALC: begin
               if (mplier_q[0])
                  acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
            end
            FIX: begin
               result_q <= neg_q ? -acc_q : acc_q;
               done_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed and randomized checks of mult_seq at
// WIDTH=32 and WIDTH=8 against an arithmetic reference.
module tb_mult_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mult_seq_if #(.WIDTH(32)) if32 ();
   mult_seq_if #(.WIDTH(8))  if8 ();

   mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
   mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

   function automatic logic [63:0] ref32(bit s, logic [31:0] a, logic [31:0] b);
      if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic logic [15:0] ref8(bit s, logic [7:0] a, logic [7:0] b);
      if (s) return 16'(int'($signed(a)) * int'($signed(b)));
      return 16'({8'b0, a} * {8'b0, b});
   endfunction

   // Issue one op from an idle negedge; returns on the done negedge.
   // lat counts edges after the accepting edge (-1 on timeout).
   task automatic op32(input bit s, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] r, output int lat,
                       output bit busy_ok, output bit stable);
      logic [63:0] prev;
      prev = if32.result;
      if32.start = 1'b1;
      if32.is_signed = s;
      if32.a = a;
      if32.b = b;
      @(negedge clk);
      if32.start = 1'b0;
      if32.a = $urandom;
      if32.b = $urandom;
      lat = -1;
      busy_ok = (if32.busy === 1'b1);
      stable = 1'b1;
      for (int e = 1; e <= 100; e++) begin
         @(negedge clk);
         if (if32.done === 1'b1) begin
            lat = e;
            busy_ok = busy_ok && (if32.busy === 1'b0);
            break;
         end
         busy_ok = busy_ok && (if32.busy === 1'b1);
         stable = stable && (if32.result === prev);
      end
      r = if32.result;
   endtask

   task automatic test_reset;
      if32.start = 0; if32.is_signed = 0; if32.a = 0; if32.b = 0;
      if8.start = 0;  if8.is_signed = 0;  if8.a = 0;  if8.b = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks += 6;
      if (if32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy32 got %b want 0", if32.busy); end
      if (if32.done !== 1'b0) begin errors++; $display("FAIL reset_done32 got %b want 0", if32.done); end
      if (if32.result !== 64'h0) begin errors++; $display("FAIL reset_result32 got %h want 0", if32.result); end
      if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b want 0", if8.busy); end
      if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b want 0", if8.done); end
      if (if8.result !== 16'h0) begin errors++; $display("FAIL reset_result8 got %h want 0", if8.result); end
   endtask

   task automatic test_directed;
      bit          ts[5] = '{1, 0, 1, 1, 1};
      logic [31:0] ta[5] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] tb[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
      logic [63:0] te[5] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFE_0000_0001, 64'h1,
                             64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
      logic [63:0] r;
      int          lat;
      bit          bok, st;
      for (int i = 0; i < 5; i++) begin
         op32(ts[i], ta[i], tb[i], r, lat, bok, st);
         checks += 3;
         if (r !== te[i]) begin errors++; $display("FAIL directed%0d_result got %h want %h", i, r, te[i]); end
         if (lat != 33) begin errors++; $display("FAIL directed%0d_latency got %0d want 33", i, lat); end
         if (!bok) begin errors++; $display("FAIL directed%0d_busy got bad busy profile want high until done", i); end
      end
   endtask

   task automatic test_ignore_start;
      logic [63:0] exp;
      int          lat;
      int          extra;
      exp = ref32(1'b1, -32'sd12345, 32'd678);
      if32.start = 1'b1; if32.is_signed = 1'b1;
      if32.a = -32'sd12345; if32.b = 32'd678;
      @(negedge clk);
      if32.start = 1'b0;
      repeat (5) @(negedge clk);
      if32.start = 1'b1; if32.is_signed = 1'b0;
      if32.a = 32'hDEAD_BEEF; if32.b = 32'h1234_5678;
      @(negedge clk);
      if32.start = 1'b0;
      lat = -1;
      for (int e = 7; e <= 100; e++) begin
         @(negedge clk);
         if (if32.done === 1'b1) begin lat = e; break; end
      end
      checks += 2;
      if (lat != 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", lat); end
      if (if32.result !== exp) begin errors++; $display("FAIL ignore_result got %h want %h", if32.result, exp); end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (if32.done === 1'b1 || if32.busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL ignore_no_second_op got %0d active cycles want 0", extra); end
   endtask

   task automatic test_back_to_back;
      logic [63:0] r;
      int          lat;
      bit          bok, st;
      logic [31:0] a1, b1, a2, b2;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      op32(1'b0, a1, b1, r, lat, bok, st);
      checks++;
      if (r !== ref32(1'b0, a1, b1)) begin errors++; $display("FAIL b2b_first got %h want %h", r, ref32(1'b0, a1, b1)); end
      op32(1'b1, a2, b2, r, lat, bok, st);
      checks += 4;
      if (r !== ref32(1'b1, a2, b2)) begin errors++; $display("FAIL b2b_second got %h want %h", r, ref32(1'b1, a2, b2)); end
      if (lat != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
      if (!bok) begin errors++; $display("FAIL b2b_busy got bad busy profile want high until done"); end
      if (!st) begin errors++; $display("FAIL b2b_result_hold got changing result want held until done"); end
   endtask

   task automatic test_random32;
      logic [63:0] r;
      int          lat;
      bit          bok, st, s;
      logic [31:0] a, b;
      for (int i = 0; i < 100; i++) begin
         s = 1'($urandom); a = $urandom; b = $urandom;
         if (i % 4 == 0) a = 32'h8000_0000;
         if (i % 5 == 0) b = 32'h0;
         op32(s, a, b, r, lat, bok, st);
         checks += 2;
         if (r !== ref32(s, a, b)) begin errors++; $display("FAIL rand32_%0d_result got %h want %h", i, r, ref32(s, a, b)); end
         if (lat != 33) begin errors++; $display("FAIL rand32_%0d_latency got %0d want 33", i, lat); end
      end
   endtask

   task automatic test_reset_mid;
      logic [63:0] r;
      int          lat;
      int          extra;
      bit          bok, st;
      if32.start = 1'b1; if32.is_signed = 1'b1;
      if32.a = 32'd5; if32.b = 32'd9;
      @(negedge clk);
      if32.start = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks += 3;
      if (if32.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", if32.busy); end
      if (if32.result !== 64'h0) begin errors++; $display("FAIL midreset_result got %h want 0", if32.result); end
      if (if32.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", if32.done); end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (if32.done === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses want 0", extra); end
      reset = 1'b1; if32.start = 1'b1;
      if32.a = 32'd3; if32.b = 32'd4;
      @(negedge clk);
      reset = 1'b0; if32.start = 1'b0;
      checks++;
      if (if32.busy !== 1'b0) begin errors++; $display("FAIL reset_start_busy got %b want 0", if32.busy); end
      op32(1'b1, 32'h0, 32'hFFFF_FFFF, r, lat, bok, st);
      checks += 2;
      if (r !== 64'h0) begin errors++; $display("FAIL post_reset_result got %h want 0", r); end
      if (lat != 33) begin errors++; $display("FAIL post_reset_latency got %0d want 33", lat); end
   endtask

   task automatic test_random8;
      bit         s;
      logic [7:0] a, b;
      int         lat;
      for (int i = 0; i < 2000; i++) begin
         s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
         if8.start = 1'b1; if8.is_signed = s; if8.a = a; if8.b = b;
         @(negedge clk);
         if8.start = 1'b0;
         if8.a = 8'($urandom); if8.b = 8'($urandom);
         lat = -1;
         for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            if (if8.done === 1'b1) begin lat = e; break; end
         end
         checks += 2;
         if (lat != 9) begin errors++; $display("FAIL rand8_%0d_latency got %0d want 9", i, lat); end
         if (if8.result !== ref8(s, a, b)) begin
            errors++;
            $display("FAIL rand8_%0d_result s=%b a=%h b=%h got %h want %h", i, s, a, b, if8.result, ref8(s, a, b));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_random32();
      test_reset_mid();
      test_random8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
